ex_mem_latch: RTL and testbench

- EX/MEM pipeline register directly downstream of the ALU in the pipelined MIPS datapath.
- Captures the ALU result and flags, plus the control and data bits carried through from ID/EX.
- Resolves BEQ/BNE from zero_flag and suppresses writes on signed-arithmetic overflow.
- Holds a sticky halt, supports stall (hold) and flush (bubble), and presents registered outputs to the MEM stage.

---
 rtl/ex_mem_latch.sv | 215 +++++++++++++++++++++
 tb/tb_ex_mem_latch.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_latch.sv
// ============================================================================
// ex_mem_latch
// ----------------------------------------------------------------------------
// EX/MEM pipeline register that sits directly after the ALU in the pipelined
// MIPS datapath. It captures the ALU result and flags, along with the control
// and data bits carried through from ID/EX. It also does the following:
//   - resolves BEQ/BNE from the ALU zero flag,
//   - suppresses register and memory writes when a checked signed add/sub
//     overflows, and raises a trap flag instead,
//   - keeps a saturating count of overflow traps,
//   - keeps a sticky halt flag once a real HALT instruction has been captured,
//   - supports stall (en=0 holds everything) and flush (bubble insertion).
// All outputs are registered and go straight to the MEM stage.
//
// Edge priority: RST > flush > en > hold.
//
// Parameters:
//   WORD_W     datapath width (must match word_t of cpu_types_pkg)
//   REG_AW     register-file write-select width
//   OVF_CNT_W  width of the saturating overflow-event counter
//
// Ports:
//   CLK             in   clock, rising edge
//   RST             in   synchronous active-high reset
//   en              in   advance: capture this edge (low = stall)
//   flush           in   insert a bubble this edge, overrides en
//   ex_valid        in   EX stage holds a real instruction
//   alu_out         in   ALU result
//   zero_flag       in   ALU zero flag
//   overflow_flag   in   ALU signed overflow flag
//   ex_chk_ovf      in   instruction traps on overflow (ADD/ADDI/SUB)
//   ex_beq, ex_bne  in   branch type
//   ex_br_target    in   computed branch target
//   ex_store_data   in   rt value for SW
//   ex_dREN/ex_dWEN in   load / store request
//   ex_regwr        in   writes register file
//   ex_wsel         in   destination register
//   ex_halt         in   HALT instruction
//   mem_*           out  registered MEM-stage view of the above
//   mem_br_taken    out  branch resolved taken
//   mem_ovf_exc     out  overflow trap for the latched instruction
//   halt            out  sticky halt
//   ovf_count       out  saturating count of overflow traps
// ============================================================================
module ex_mem_latch #(
    parameter int WORD_W    = 32,
    parameter int REG_AW    = 5,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 ex_valid,
    input  logic [WORD_W-1:0]    alu_out,
    input  logic                 zero_flag,
    input  logic                 overflow_flag,
    input  logic                 ex_chk_ovf,
    input  logic                 ex_beq,
    input  logic                 ex_bne,
    input  logic [WORD_W-1:0]    ex_br_target,
    input  logic [WORD_W-1:0]    ex_store_data,
    input  logic                 ex_dREN,
    input  logic                 ex_dWEN,
    input  logic                 ex_regwr,
    input  logic [REG_AW-1:0]    ex_wsel,
    input  logic                 ex_halt,
    output logic                 mem_valid,
    output logic [WORD_W-1:0]    mem_result,
    output logic [WORD_W-1:0]    mem_store_data,
    output logic                 mem_dREN,
    output logic                 mem_dWEN,
    output logic                 mem_regwr,
    output logic [REG_AW-1:0]    mem_wsel,
    output logic                 mem_br_taken,
    output logic [WORD_W-1:0]    mem_br_addr,
    output logic                 mem_ovf_exc,
    output logic                 halt,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    // Halt tracking: once a real HALT has been captured we stay halted until
    // reset. The pipeline itself keeps capturing; upstream squashes fetch.
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } halt_state_t;

    halt_state_t halt_state;
    halt_state_t halt_state_next;

    logic capture;
    logic cap_ovf;
    logic cap_br_taken;
    logic cap_regwr;
    logic cap_dren;
    logic cap_dwen;
    logic ovf_cnt_full;

    // Decode what this edge would latch if it turns out to be a capture edge.
    // Every control bit is qualified by ex_valid, so a bubble coming out of EX
    // can never leak a write, branch or trap into MEM. An overflowing checked
    // instruction loses its side effects (register/memory writes) and becomes
    // a trap instead. Both branch terms are OR'd so that the illegal case of
    // BEQ and BNE together still gives a well-defined result.
    always_comb begin
        capture      = 1'b0;
        cap_ovf      = 1'b0;
        cap_br_taken = 1'b0;
        cap_regwr    = 1'b0;
        cap_dren     = 1'b0;
        cap_dwen     = 1'b0;
        ovf_cnt_full = 1'b0;

        capture      = en & ~flush;
        cap_ovf      = ex_valid & ex_chk_ovf & overflow_flag;
        cap_br_taken = ex_valid & ((ex_beq & zero_flag) | (ex_bne & ~zero_flag));
        cap_regwr    = ex_valid & ex_regwr & ~cap_ovf;
        cap_dren     = ex_valid & ex_dREN  & ~cap_ovf;
        cap_dwen     = ex_valid & ex_dWEN  & ~cap_ovf;
        ovf_cnt_full = &ovf_count;
    end

    // Control half of the pipeline register. These are the bits that cause
    // side effects downstream, so a flush has to clear them. Stall (en=0 with
    // no flush) simply falls through and holds the previous values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_valid    <= 1'b0;
            mem_dREN     <= 1'b0;
            mem_dWEN     <= 1'b0;
            mem_regwr    <= 1'b0;
            mem_br_taken <= 1'b0;
            mem_ovf_exc  <= 1'b0;
        end else if (flush) begin
            mem_valid    <= 1'b0;
            mem_dREN     <= 1'b0;
            mem_dWEN     <= 1'b0;
            mem_regwr    <= 1'b0;
            mem_br_taken <= 1'b0;
            mem_ovf_exc  <= 1'b0;
        end else if (en) begin
            mem_valid    <= ex_valid;
            mem_dREN     <= cap_dren;
            mem_dWEN     <= cap_dwen;
            mem_regwr    <= cap_regwr;
            mem_br_taken <= cap_br_taken;
            mem_ovf_exc  <= cap_ovf;
        end
    end

    // Data half of the pipeline register. These fields mean nothing while
    // the control half says the slot is a bubble, so a flush just leaves them
    // alone. This avoids spending enable logic on clearing them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_wsel       <= '0;
            mem_br_addr    <= '0;
        end else if (capture) begin
            mem_result     <= alu_out;
            mem_store_data <= ex_store_data;
            mem_wsel       <= ex_wsel;
            mem_br_addr    <= ex_br_target;
        end
    end

    // Overflow-trap counter. It only steps on a real capture edge, so a
    // stalled trapping instruction is counted once, however long the stall.
    // A flushed instruction is never counted. The counter sticks at
    // all-ones instead of wrapping, so software reading it never sees a
    // small value after many traps.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_count <= '0;
        end else if (capture && cap_ovf && !ovf_cnt_full) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

    // Halt state register. Only reset can leave HALTED.
    always_ff @(posedge CLK) begin
        if (RST) begin
            halt_state <= RUN;
        end else begin
            halt_state <= halt_state_next;
        end
    end

    // Halt next-state logic. A HALT moves us to HALTED only when it is
    // actually captured. That means a HALT that is stalled or flushed on this
    // edge does not count. It can still count later, once it is captured.
    always_comb begin
        halt_state_next = halt_state;
        case (halt_state)
            RUN: begin
                if (capture && ex_valid && ex_halt) begin
                    halt_state_next = HALTED;
                end
            end
            HALTED: begin
                halt_state_next = HALTED;
            end
            default: begin
                halt_state_next = RUN;
            end
        endcase
    end

    // The halt output is decoded directly from the state register, so it
    // is registered and glitch-free.
    assign halt = (halt_state == HALTED);

endmodule

// File: tb/tb_ex_mem_latch.sv
// ============================================================================
// tb_ex_mem_latch
// ----------------------------------------------------------------------------
// Directed and short random stimulus for ex_mem_latch. Each step drives the
// inputs and computes what the registered outputs should be after the next
// rising edge. It pushes that expected value onto a scoreboard queue, and
// after the edge it pops the entry and compares it with the outputs.
// ============================================================================
module tb_ex_mem_latch;

    localparam int WORD_W    = 32;
    localparam int REG_AW    = 5;
    localparam int OVF_CNT_W = 8;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 en;
    logic                 flush;
    logic                 ex_valid;
    logic [WORD_W-1:0]    alu_out;
    logic                 zero_flag;
    logic                 overflow_flag;
    logic                 ex_chk_ovf;
    logic                 ex_beq;
    logic                 ex_bne;
    logic [WORD_W-1:0]    ex_br_target;
    logic [WORD_W-1:0]    ex_store_data;
    logic                 ex_dREN;
    logic                 ex_dWEN;
    logic                 ex_regwr;
    logic [REG_AW-1:0]    ex_wsel;
    logic                 ex_halt;
    logic                 mem_valid;
    logic [WORD_W-1:0]    mem_result;
    logic [WORD_W-1:0]    mem_store_data;
    logic                 mem_dREN;
    logic                 mem_dWEN;
    logic                 mem_regwr;
    logic [REG_AW-1:0]    mem_wsel;
    logic                 mem_br_taken;
    logic [WORD_W-1:0]    mem_br_addr;
    logic                 mem_ovf_exc;
    logic                 halt;
    logic [OVF_CNT_W-1:0] ovf_count;

    // Expected output snapshot. dataKnown is cleared after a flush, because
    // the data fields are don't-care from that point until the next capture.
    typedef struct packed {
        logic                 dataKnown;
        logic                 valid;
        logic [WORD_W-1:0]    result;
        logic [WORD_W-1:0]    storeData;
        logic                 dren;
        logic                 dwen;
        logic                 regwr;
        logic [REG_AW-1:0]    wsel;
        logic                 brTaken;
        logic [WORD_W-1:0]    brAddr;
        logic                 ovfExc;
        logic                 halt;
        logic [OVF_CNT_W-1:0] ovfCount;
    } exp_t;

    exp_t sbQueue[$];
    exp_t model;
    int   assertCount = 0;
    int   failCount   = 0;

    ex_mem_latch #(
        .WORD_W    (WORD_W),
        .REG_AW    (REG_AW),
        .OVF_CNT_W (OVF_CNT_W)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .en             (en),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .alu_out        (alu_out),
        .zero_flag      (zero_flag),
        .overflow_flag  (overflow_flag),
        .ex_chk_ovf     (ex_chk_ovf),
        .ex_beq         (ex_beq),
        .ex_bne         (ex_bne),
        .ex_br_target   (ex_br_target),
        .ex_store_data  (ex_store_data),
        .ex_dREN        (ex_dREN),
        .ex_dWEN        (ex_dWEN),
        .ex_regwr       (ex_regwr),
        .ex_wsel        (ex_wsel),
        .ex_halt        (ex_halt),
        .mem_valid      (mem_valid),
        .mem_result     (mem_result),
        .mem_store_data (mem_store_data),
        .mem_dREN       (mem_dREN),
        .mem_dWEN       (mem_dWEN),
        .mem_regwr      (mem_regwr),
        .mem_wsel       (mem_wsel),
        .mem_br_taken   (mem_br_taken),
        .mem_br_addr    (mem_br_addr),
        .mem_ovf_exc    (mem_ovf_exc),
        .halt           (halt),
        .ovf_count      (ovf_count)
    );

    always #5 CLK = ~CLK;

    // Single comparison point: counts the comparison and reports any miss.
    task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assertCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drop every input to its idle value. en stays high so that steps capture
    // by default.
    task automatic clearInputs();
        RST           = 1'b0;
        en            = 1'b1;
        flush         = 1'b0;
        ex_valid      = 1'b0;
        alu_out       = '0;
        zero_flag     = 1'b0;
        overflow_flag = 1'b0;
        ex_chk_ovf    = 1'b0;
        ex_beq        = 1'b0;
        ex_bne        = 1'b0;
        ex_br_target  = '0;
        ex_store_data = '0;
        ex_dREN       = 1'b0;
        ex_dWEN       = 1'b0;
        ex_regwr      = 1'b0;
        ex_wsel       = '0;
        ex_halt       = 1'b0;
    endtask

    // Compute the expected post-edge outputs from the inputs as currently
    // driven, push them to the scoreboard, then let the edge happen and move
    // 1 time unit past it.
    task automatic applyStimulus();
        logic ovf;
        ovf = ex_valid & ex_chk_ovf & overflow_flag;
        if (RST) begin
            model           = '0;
            model.dataKnown = 1'b1;
        end else if (flush) begin
            model.valid     = 1'b0;
            model.dren      = 1'b0;
            model.dwen      = 1'b0;
            model.regwr     = 1'b0;
            model.brTaken   = 1'b0;
            model.ovfExc    = 1'b0;
            model.dataKnown = 1'b0;
        end else if (en) begin
            model.dataKnown = 1'b1;
            model.valid     = ex_valid;
            model.result    = alu_out;
            model.storeData = ex_store_data;
            model.wsel      = ex_wsel;
            model.brAddr    = ex_br_target;
            model.ovfExc    = ovf;
            model.regwr     = ex_valid & ex_regwr & ~ovf;
            model.dren      = ex_valid & ex_dREN & ~ovf;
            model.dwen      = ex_valid & ex_dWEN & ~ovf;
            model.brTaken   = ex_valid & ((ex_beq & zero_flag) | (ex_bne & ~zero_flag));
            if (ovf && model.ovfCount != 8'hFF) model.ovfCount = model.ovfCount + 8'd1;
            if (ex_valid && ex_halt) model.halt = 1'b1;
        end
        sbQueue.push_back(model);
        @(posedge CLK);
        #1;
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic checkOutput(input string tag);
        exp_t e;
        if (sbQueue.size() == 0) begin
            checkField({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sbQueue.pop_front();
        checkField({tag, "_valid"},    32'(mem_valid),    32'(e.valid));
        checkField({tag, "_dREN"},     32'(mem_dREN),     32'(e.dren));
        checkField({tag, "_dWEN"},     32'(mem_dWEN),     32'(e.dwen));
        checkField({tag, "_regwr"},    32'(mem_regwr),    32'(e.regwr));
        checkField({tag, "_br_taken"}, 32'(mem_br_taken), 32'(e.brTaken));
        checkField({tag, "_ovf_exc"},  32'(mem_ovf_exc),  32'(e.ovfExc));
        checkField({tag, "_halt"},     32'(halt),         32'(e.halt));
        checkField({tag, "_ovf_count"}, 32'(ovf_count),   32'(e.ovfCount));
        if (e.dataKnown) begin
            checkField({tag, "_result"},     mem_result,     e.result);
            checkField({tag, "_store_data"}, mem_store_data, e.storeData);
            checkField({tag, "_wsel"},       32'(mem_wsel),  32'(e.wsel));
            checkField({tag, "_br_addr"},    mem_br_addr,    e.brAddr);
        end
    endtask

    task automatic step(input string tag);
        applyStimulus();
        checkOutput(tag);
    endtask

    initial begin
        model = '0;
        model.dataKnown = 1'b1;

        // Reset with every input high.
        clearInputs();
        RST = 1'b1; en = 1'b1; flush = 1'b1; ex_valid = 1'b1; alu_out = '1;
        zero_flag = 1'b1; overflow_flag = 1'b1; ex_chk_ovf = 1'b1; ex_beq = 1'b1;
        ex_bne = 1'b1; ex_br_target = '1; ex_store_data = '1; ex_dREN = 1'b1;
        ex_dWEN = 1'b1; ex_regwr = 1'b1; ex_wsel = '1; ex_halt = 1'b1;
        step("reset0");
        step("reset1");
        checkField("reset_result", mem_result, 32'h0);
        checkField("reset_halt", 32'(halt), 32'h0);

        // ADD capture.
        clearInputs();
        ex_valid = 1'b1; ex_regwr = 1'b1; ex_wsel = 5'd8; alu_out = 32'h0000_0010;
        step("add");
        checkField("add_wsel", 32'(mem_wsel), 32'd8);
        checkField("add_result", mem_result, 32'h10);
        checkField("add_regwr", 32'(mem_regwr), 32'd1);

        // Overflow trap, then a 3-cycle stall with the same inputs.
        clearInputs();
        ex_valid = 1'b1; ex_chk_ovf = 1'b1; overflow_flag = 1'b1; ex_regwr = 1'b1;
        alu_out = 32'h8000_0000;
        step("ovf");
        checkField("ovf_exc", 32'(mem_ovf_exc), 32'd1);
        checkField("ovf_regwr", 32'(mem_regwr), 32'd0);
        checkField("ovf_count1", 32'(ovf_count), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step("ovf_stall");
        checkField("ovf_stall_count", 32'(ovf_count), 32'd1);

        // Branches.
        clearInputs();
        ex_valid = 1'b1; ex_beq = 1'b1; zero_flag = 1'b1; ex_br_target = 32'h0000_0040;
        step("beq_taken");
        checkField("beq_taken", 32'(mem_br_taken), 32'd1);
        checkField("beq_addr", mem_br_addr, 32'h40);
        clearInputs();
        ex_valid = 1'b1; ex_bne = 1'b1; zero_flag = 1'b1;
        step("bne_not_taken");
        checkField("bne_z1", 32'(mem_br_taken), 32'd0);
        zero_flag = 1'b0;
        step("bne_taken");
        checkField("bne_z0", 32'(mem_br_taken), 32'd1);
        ex_beq = 1'b1; zero_flag = 1'b1;
        step("beq_bne_both");

        // Invalid slot with every control input high.
        clearInputs();
        ex_valid = 1'b0; ex_chk_ovf = 1'b1; overflow_flag = 1'b1; ex_beq = 1'b1;
        ex_dREN = 1'b1; ex_dWEN = 1'b1; ex_regwr = 1'b1; ex_halt = 1'b1;
        step("invalid");

        // Load capture.
        clearInputs();
        ex_valid = 1'b1; ex_dREN = 1'b1; ex_regwr = 1'b1; alu_out = 32'h0000_1000; ex_wsel = 5'd3;
        step("load");

        // Flush beats en for a valid SW. Then the same SW is captured.
        clearInputs();
        ex_valid = 1'b1; ex_dWEN = 1'b1; ex_store_data = 32'hDEAD_BEEF; alu_out = 32'h0000_0200;
        flush = 1'b1;
        step("flush_sw");
        checkField("flush_dwen", 32'(mem_dWEN), 32'd0);
        flush = 1'b0;
        step("after_flush_sw");
        checkField("sw_dwen", 32'(mem_dWEN), 32'd1);

        // Halt: a stalled or flushed HALT must not set halt.
        clearInputs();
        ex_valid = 1'b1; ex_halt = 1'b1; en = 1'b0;
        step("halt_stalled");
        flush = 1'b1; en = 1'b1;
        step("halt_flushed");
        checkField("halt_flushed", 32'(halt), 32'd0);
        flush = 1'b0;
        step("halt_set");
        checkField("halt_set", 32'(halt), 32'd1);
        clearInputs();
        flush = 1'b1;
        step("halt_keep_flush");
        flush = 1'b0; ex_valid = 1'b1; ex_regwr = 1'b1; ex_wsel = 5'd9;
        step("halt_keep_capture");
        checkField("halt_sticky", 32'(halt), 32'd1);
        RST = 1'b1;
        step("halt_reset");

        // Reset asserted mid-stall after building up state.
        clearInputs();
        ex_valid = 1'b1; ex_chk_ovf = 1'b1; overflow_flag = 1'b1; ex_halt = 1'b1;
        step("prestall");
        en = 1'b0;
        step("stall");
        RST = 1'b1;
        step("reset_mid_stall");
        checkField("rst_stall_count", 32'(ovf_count), 32'd0);

        // Saturation: 255 traps, then one more.
        clearInputs();
        ex_valid = 1'b1; ex_chk_ovf = 1'b1; overflow_flag = 1'b1;
        for (int i = 0; i < 255; i++) step("sat_fill");
        checkField("sat_255", 32'(ovf_count), 32'hFF);
        step("sat_extra");
        checkField("sat_hold", 32'(ovf_count), 32'hFF);

        // Short random phase against the model.
        clearInputs();
        RST = 1'b1;
        step("rand_reset");
        for (int i = 0; i < 80; i++) begin
            RST           = ($urandom_range(0, 29) == 0);
            en            = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 5) == 0);
            ex_valid      = 1'($urandom_range(0, 1));
            alu_out       = $urandom;
            zero_flag     = 1'($urandom_range(0, 1));
            overflow_flag = 1'($urandom_range(0, 1));
            ex_chk_ovf    = 1'($urandom_range(0, 1));
            ex_beq        = 1'($urandom_range(0, 1));
            ex_bne        = 1'($urandom_range(0, 1));
            ex_br_target  = $urandom;
            ex_store_data = $urandom;
            ex_dREN       = 1'($urandom_range(0, 1));
            ex_dWEN       = 1'($urandom_range(0, 1));
            ex_regwr      = 1'($urandom_range(0, 1));
            ex_wsel       = 5'($urandom_range(0, 31));
            ex_halt       = ($urandom_range(0, 9) == 0);
            step("random");
        end

        if (sbQueue.size() != 0) checkField("sb_leftover", 32'(sbQueue.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
